// File: rtl/gpreg_xfer_ctrl_pkg.sv
// gpreg_xfer_ctrl_pkg: opcode and sequencer state encodings shared by the transfer controller.
package gpreg_xfer_ctrl_pkg;
   typedef enum logic [1:0] {OP_MOV = 2'b00, OP_ALU = 2'b01, OP_LDEXT = 2'b10, OP_RSVD = 2'b11} op_t;
   typedef enum logic [2:0] {IDLE, DRIVE, LOAD, DONE, GAP} state_t;
   // bit 2: SRC_A used, bit 1: SRC_B used, bit 0: DST used
   function automatic logic [2:0] idx_used(input op_t op);
      return op == OP_MOV ? 3'b101 : op == OP_ALU ? 3'b111 : op == OP_LDEXT ? 3'b001 : 3'b000;
   endfunction
endpackage

// File: rtl/gpreg_xfer_ctrl_if.sv
// gpreg_xfer_ctrl_if: decoder request/ack handshake plus the register-bank strobe vectors.
interface gpreg_xfer_ctrl_if #(parameter int NREGS = 4, parameter int IW = 2);
   logic             REQ;
   logic [1:0]       OP;
   logic [IW-1:0]    SRC_A, SRC_B, DST;
   logic             ACK, BUSY, ERR;
   logic [NREGS-1:0] LOAD_bar, ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar;
   logic             ALU_ASSERT_bar, EXT_ASSERT_bar;
   modport master (output REQ, OP, SRC_A, SRC_B, DST,
                   input ACK, BUSY, ERR, LOAD_bar, ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar,
                         ALU_ASSERT_bar, EXT_ASSERT_bar);
   modport slave  (input REQ, OP, SRC_A, SRC_B, DST,
                   output ACK, BUSY, ERR, LOAD_bar, ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar,
                          ALU_ASSERT_bar, EXT_ASSERT_bar);
endinterface

// File: rtl/gpreg_xfer_ctrl_onehot_dec_bar.sv
// gpreg_xfer_ctrl_onehot_dec_bar: index to active-low one-hot strobe vector, all-ones when disabled.
module gpreg_xfer_ctrl_onehot_dec_bar #(parameter int NREGS = 4, parameter int IW = 2) (
   input  logic             en,
   input  logic [IW-1:0]    idx,
   output logic [NREGS-1:0] y_bar
);
   for (genvar i = 0; i < NREGS; i++) begin : g_bit
      assign y_bar[i] = !(en && idx == IW'(i));
   end
endmodule

// File: rtl/gpreg_xfer_ctrl.sv
// gpreg_xfer_ctrl: break-before-make register transfer sequencer (IDLE/DRIVE/LOAD/DONE/GAP).
// Every output is a flop loaded from the next-state decode, so strobes are glitch-free.
module gpreg_xfer_ctrl
   import gpreg_xfer_ctrl_pkg::*;
#(parameter int NREGS = 4, parameter int IW = 2) (
   input logic CLK,
   input logic RST_bar,
   gpreg_xfer_ctrl_if.slave bus
);
   state_t           state, nxt;
   op_t              op_q, op_c;
   logic [IW-1:0]    a_q, b_q, d_q, a_c, b_c, d_c;
   logic [2:0]       used;
   logic             idle, err_in, err_q, err_c, drv, ld;
   logic [NREGS-1:0] as_n, lhs_n, rhs_n, ld_n;
   logic [NREGS-1:0] as_r, lhs_r, rhs_r, ld_r;
   logic             ack_r, busy_r, err_r, alu_r, ext_r;
   assign idle   = state == IDLE;
   assign used   = idx_used(op_t'(bus.OP));
   assign err_in = op_t'(bus.OP) == OP_RSVD
                || (used[2] && 32'(bus.SRC_A) >= NREGS)
                || (used[1] && 32'(bus.SRC_B) >= NREGS)
                || (used[0] && 32'(bus.DST) >= NREGS);
   // In IDLE the incoming request feeds the decode so strobes are ready the cycle after accept
   assign op_c  = idle ? op_t'(bus.OP) : op_q;
   assign a_c   = idle ? bus.SRC_A : a_q;
   assign b_c   = idle ? bus.SRC_B : b_q;
   assign d_c   = idle ? bus.DST : d_q;
   assign err_c = idle ? err_in : err_q;
   always_ff @(posedge CLK or negedge RST_bar)
      if (!RST_bar) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = state == IDLE  ? (bus.REQ ? (err_in ? DONE : DRIVE) : IDLE) :
            state == DRIVE ? LOAD :
            state == LOAD  ? DONE :
            state == DONE  ? GAP : IDLE;
   always_comb begin
      drv = nxt == DRIVE || nxt == LOAD;
      ld  = nxt == LOAD;
   end
   gpreg_xfer_ctrl_onehot_dec_bar #(.NREGS(NREGS), .IW(IW)) u_as
      (.en(drv && op_c == OP_MOV), .idx(a_c), .y_bar(as_n));
   gpreg_xfer_ctrl_onehot_dec_bar #(.NREGS(NREGS), .IW(IW)) u_lhs
      (.en(drv && op_c == OP_ALU), .idx(a_c), .y_bar(lhs_n));
   gpreg_xfer_ctrl_onehot_dec_bar #(.NREGS(NREGS), .IW(IW)) u_rhs
      (.en(drv && op_c == OP_ALU), .idx(b_c), .y_bar(rhs_n));
   gpreg_xfer_ctrl_onehot_dec_bar #(.NREGS(NREGS), .IW(IW)) u_ld
      (.en(ld), .idx(d_c), .y_bar(ld_n));
   always_ff @(posedge CLK or negedge RST_bar)
      if (!RST_bar) begin
         op_q   <= OP_MOV;
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         err_q  <= 1'b0;
         as_r   <= '1;
         lhs_r  <= '1;
         rhs_r  <= '1;
         ld_r   <= '1;
         alu_r  <= 1'b1;
         ext_r  <= 1'b1;
         ack_r  <= 1'b0;
         busy_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         op_q   <= op_c;
         a_q    <= a_c;
         b_q    <= b_c;
         d_q    <= d_c;
         err_q  <= err_c;
         as_r   <= as_n;
         lhs_r  <= lhs_n;
         rhs_r  <= rhs_n;
         ld_r   <= ld_n;
         alu_r  <= !(drv && op_c == OP_ALU);
         ext_r  <= !(drv && op_c == OP_LDEXT);
         ack_r  <= nxt == DONE;
         busy_r <= nxt == DRIVE || nxt == LOAD || nxt == DONE;
         err_r  <= nxt == DONE && err_c;
      end
   assign bus.ASSERT_bar     = as_r;
   assign bus.ASSERT_LHS_bar = lhs_r;
   assign bus.ASSERT_RHS_bar = rhs_r;
   assign bus.LOAD_bar       = ld_r;
   assign bus.ALU_ASSERT_bar = alu_r;
   assign bus.EXT_ASSERT_bar = ext_r;
   assign bus.ACK            = ack_r;
   assign bus.BUSY           = busy_r;
   assign bus.ERR            = err_r;
endmodule

// File: doc/gpreg_xfer_ctrl.md
# gpreg_xfer_ctrl

Register-transfer sequencer for a bank of 8-bit general purpose registers built from 74377 latches and 74244 bus drivers. It accepts one transfer request at a time from the instruction decoder and drives the active-low strobes of every register: LOAD_bar, ASSERT_bar, ASSERT_LHS_bar and ASSERT_RHS_bar. It also drives the ALU-to-bus and external-to-bus enables. The sequence is break-before-make, so the main bus never has two drivers.

## Interface
- NREGS, 4, number of registers in the bank (2..8).
- IW, 2, register index width; 2**IW >= NREGS.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST_bar  in  1  asynchronous, active-low reset.
- REQ  in  1  transfer request; held high with OP/SRC_A/SRC_B/DST stable until ACK.
- OP  in  2  00 MOV, 01 ALU, 10 LDEXT, 11 reserved.
- SRC_A  in  IW  MOV source; ALU LHS source.
- SRC_B  in  IW  ALU RHS source.
- DST  in  IW  destination register.
- ACK  out  1  one-cycle completion pulse.
- BUSY  out  1  high from request accept through ACK.
- ERR  out  1  valid with ACK; high for a reserved OP or any used index >= NREGS.
- LOAD_bar  out  NREGS  per-register load enable.
- ASSERT_bar  out  NREGS  per-register main-bus drive.
- ASSERT_LHS_bar  out  NREGS  per-register ALU LHS drive.
- ASSERT_RHS_bar  out  NREGS  per-register ALU RHS drive.
- ALU_ASSERT_bar  out  1  ALU result onto the main bus.
- EXT_ASSERT_bar  out  1  external source (memory/IO) onto the main bus.

## Operation
- All outputs are registered. Reset value: every *_bar output is all-ones; ACK, BUSY and ERR are 0; state is IDLE.
- IDLE: when REQ=1, latch OP and the three indices, decode errors, then go to DRIVE. BUSY becomes 1.
  - On error, go directly to DONE with ERR=1. No strobe is ever asserted for an errored request.
- DRIVE: assert the source drivers, with all LOAD_bar still high.
  - MOV: ASSERT_bar[SRC_A]=0.
  - ALU: ASSERT_LHS_bar[SRC_A]=0, ASSERT_RHS_bar[SRC_B]=0, ALU_ASSERT_bar=0.
  - LDEXT: EXT_ASSERT_bar=0.
- LOAD: keep the same drivers asserted and set LOAD_bar[DST]=0 for exactly one cycle. The register captures on the rising edge that ends LOAD.
- DONE: release all drivers and loads. ACK=1 for one cycle, ERR valid, BUSY still 1. Next state is IDLE.
- IDLE ignores REQ for the first cycle after DONE. That cycle is the break interval; BUSY=0 in it. REQ still high in that cycle is not re-accepted. The decoder must drop REQ on seeing ACK.
- Special cases:
  - MOV with SRC_A==DST is legal and rewrites the same value.
  - ALU with SRC_A==SRC_B is legal; both LHS and RHS drivers for that register are enabled.
- Invariants:
  - At most one main-bus driver (ASSERT_bar bits, ALU_ASSERT_bar, EXT_ASSERT_bar) is low in any cycle.
  - At most one LOAD_bar bit is low in any cycle.
  - No LOAD_bar bit is low outside LOAD.
- Reset mid-operation: outputs return to reset values asynchronously and the in-flight transfer is abandoned.

## Timing
- The request is accepted at edge E0 (REQ=1 in IDLE).
- Valid request: DRIVE in the cycle after E0, LOAD in the next, ACK in the next. ACK is high 3 cycles after acceptance.
- Errored request: ACK with ERR=1 in the cycle after E0.
- Throughput: one valid transfer per 5 cycles, counting REQ held back-to-back.
- The source drivers settle for a full cycle (DRIVE) before any load edge.

## Structure
- Shared header gpreg_ctrl_defs.v holds:
  - OP encodings (OP_MOV, OP_ALU, OP_LDEXT, OP_RSVD);
  - state encodings (IDLE, DRIVE, LOAD, DONE, plus a one-cycle GAP or a flag for the post-DONE break).
- Sub-module onehot_dec_bar (IW in, NREGS active-low out, plus an enable) is instantiated once per strobe vector.

## Test plan
- Reset: hold RST_bar=0 with REQ=1 -> all *_bar outputs all-ones and ACK/BUSY/ERR=0; release -> nothing happens until the next edge samples REQ.
- MOV SRC_A=1, DST=3, NREGS=4 -> DRIVE: ASSERT_bar=4'b1101; LOAD: additionally LOAD_bar=4'b0111; ACK 3 cycles after accept with ERR=0. A bench model of the register bank shows r3 equal to r1.
- ALU SRC_A=0, SRC_B=2, DST=0 -> ASSERT_LHS_bar=4'b1110, ASSERT_RHS_bar=4'b1011 and ALU_ASSERT_bar=0 for 2 cycles; LOAD_bar=4'b1110 in the second; ASSERT_bar stays all-ones.
- Errors: OP=11, and separately MOV DST=5 with NREGS=5 and IW=3 -> ACK with ERR=1 one cycle after accept; no strobe is ever low.
- Back-to-back: REQ held high across two LDEXT requests -> the second is accepted exactly 5 cycles after the first; a monitor confirms one bus driver maximum and one LOAD maximum every cycle.
- Reset asserted during LOAD -> LOAD_bar returns to all-ones before the next edge and the bench register is not updated; after release, a fresh request completes normally.
